// File: rtl/execute_stage.sv
// Execute stage of the in-order RV32I pipeline: ALU, branch/jump resolution,
// fetch redirect with wrong-path squash, and the EX/MEM pipeline register.
module execute_stage #(
   parameter int DWIDTH        = 32,
   parameter int PC_WIDTH      = 32,
   parameter int AWIDTH        = 5,
   parameter int FUNCT_WIDTH   = 3,
   parameter int OPCODE_WIDTH  = 11,
   parameter int ALU_WIDTH     = 14,
   parameter int SQUASH_CYCLES = 2
) (
   input  logic                    ex_clk,
   input  logic                    ex_rst,
   input  logic                    ex_i_ce,
   input  logic                    ex_i_stall,
   input  logic                    ex_i_flush,
   input  logic [PC_WIDTH-1:0]     ex_i_pc,
   input  logic [OPCODE_WIDTH-1:0] ex_i_opcode,
   input  logic [ALU_WIDTH-1:0]    ex_i_alu,
   input  logic [FUNCT_WIDTH-1:0]  ex_i_funct3,
   input  logic [DWIDTH-1:0]       ex_i_imm,
   input  logic [DWIDTH-1:0]       ex_i_rs1,
   input  logic [DWIDTH-1:0]       ex_i_rs2,
   input  logic [AWIDTH-1:0]       ex_i_addr_rd,
   output logic                    ex_o_ce,
   output logic [DWIDTH-1:0]       ex_o_result,
   output logic [DWIDTH-1:0]       ex_o_store_data,
   output logic [AWIDTH-1:0]       ex_o_addr_rd,
   output logic                    ex_o_rd_we,
   output logic [OPCODE_WIDTH-1:0] ex_o_opcode,
   output logic [FUNCT_WIDTH-1:0]  ex_o_funct3,
   output logic [PC_WIDTH-1:0]     ex_o_pc,
   output logic                    ex_o_change_pc,
   output logic [PC_WIDTH-1:0]     ex_o_next_pc,
   output logic                    ex_o_flush,
   output logic                    ex_o_stall,
   output logic                    ex_o_exception
);

   localparam int OP_RTYPE  = 0;
   localparam int OP_ITYPE  = 1;
   localparam int OP_LOAD   = 2;
   localparam int OP_BRANCH = 4;
   localparam int OP_JAL    = 5;
   localparam int OP_JALR   = 6;
   localparam int OP_LUI    = 7;
   localparam int OP_AUIPC  = 8;
   localparam int OP_SYSTEM = 9;
   localparam int OP_FENCE  = 10;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_XOR  = 4;
   localparam int ALU_OR   = 5;
   localparam int ALU_AND  = 6;
   localparam int ALU_SLL  = 7;
   localparam int ALU_SRL  = 8;
   localparam int ALU_SRA  = 9;
   localparam int ALU_EQ   = 10;
   localparam int ALU_NEQ  = 11;
   localparam int ALU_GE   = 12;
   localparam int ALU_GEU  = 13;

   logic [1:0]          squash_cnt;
   logic                accept;
   logic                is_jal, is_jalr, is_branch, is_jump;
   logic [DWIDTH-1:0]   op_a, op_b, alu_out, result;
   logic [4:0]          shamt;
   logic                lt_s, lt_u;
   logic [PC_WIDTH-1:0] pc_target, jalr_sum, target, link;
   logic                want_redirect, misaligned, redirect, writes_rd;

   assign is_jal    = ex_i_opcode[OP_JAL];
   assign is_jalr   = ex_i_opcode[OP_JALR];
   assign is_branch = ex_i_opcode[OP_BRANCH];
   assign is_jump   = is_jal | is_jalr;

   assign accept = ex_i_ce & ~ex_i_stall & ~ex_i_flush & (squash_cnt == 2'd0);

   assign op_a = (is_jal | ex_i_opcode[OP_AUIPC]) ? DWIDTH'(ex_i_pc) :
                 ex_i_opcode[OP_LUI]              ? '0 : ex_i_rs1;
   assign op_b = (ex_i_opcode[OP_RTYPE] | is_branch) ? ex_i_rs2 : ex_i_imm;

   assign shamt = op_b[4:0];
   assign lt_s  = $signed(op_a) < $signed(op_b);
   assign lt_u  = op_a < op_b;

   always_comb begin
      // NOTE: default first so no path through the one-hot decode infers a latch.
      alu_out = '0;
      if (ex_i_alu[ALU_ADD])  alu_out = op_a + op_b;
      if (ex_i_alu[ALU_SUB])  alu_out = op_a - op_b;
      if (ex_i_alu[ALU_SLT])  alu_out = {{(DWIDTH-1){1'b0}}, lt_s};
      if (ex_i_alu[ALU_SLTU]) alu_out = {{(DWIDTH-1){1'b0}}, lt_u};
      if (ex_i_alu[ALU_XOR])  alu_out = op_a ^ op_b;
      if (ex_i_alu[ALU_OR])   alu_out = op_a | op_b;
      if (ex_i_alu[ALU_AND])  alu_out = op_a & op_b;
      if (ex_i_alu[ALU_SLL])  alu_out = op_a << shamt;
      if (ex_i_alu[ALU_SRL])  alu_out = op_a >> shamt;
      if (ex_i_alu[ALU_SRA])  alu_out = $signed(op_a) >>> shamt;
      if (ex_i_alu[ALU_EQ])   alu_out = {{(DWIDTH-1){1'b0}}, op_a == op_b};
      if (ex_i_alu[ALU_NEQ])  alu_out = {{(DWIDTH-1){1'b0}}, op_a != op_b};
      if (ex_i_alu[ALU_GE])   alu_out = {{(DWIDTH-1){1'b0}}, ~lt_s};
      if (ex_i_alu[ALU_GEU])  alu_out = {{(DWIDTH-1){1'b0}}, ~lt_u};
   end

   assign pc_target = ex_i_pc + PC_WIDTH'(ex_i_imm);
   assign jalr_sum  = PC_WIDTH'(ex_i_rs1 + ex_i_imm);
   assign target    = is_jalr ? {jalr_sum[PC_WIDTH-1:1], 1'b0} : pc_target;
   assign link      = ex_i_pc + PC_WIDTH'(4);
   assign result    = is_jump ? DWIDTH'(link) : alu_out;

   // A misaligned target raises an exception instead of redirecting fetch.
   assign want_redirect = is_jump | (is_branch & alu_out[0]);
   assign misaligned    = target[1:0] != 2'b00;
   assign redirect      = want_redirect & ~misaligned;

   assign writes_rd = (ex_i_opcode[OP_RTYPE] | ex_i_opcode[OP_ITYPE] | ex_i_opcode[OP_LOAD] |
                       is_jump | ex_i_opcode[OP_LUI] | ex_i_opcode[OP_AUIPC]) &
                      ~(ex_i_opcode[OP_SYSTEM] | ex_i_opcode[OP_FENCE]) &
                      (ex_i_addr_rd != '0);

   assign ex_o_stall = ex_i_stall;
   assign ex_o_flush = ex_o_change_pc | ex_i_flush;

   always_ff @(posedge ex_clk or posedge ex_rst) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (ex_rst) begin
         ex_o_ce         <= 1'b0;
         ex_o_result     <= '0;
         ex_o_store_data <= '0;
         ex_o_addr_rd    <= '0;
         ex_o_rd_we      <= 1'b0;
         ex_o_opcode     <= '0;
         ex_o_funct3     <= '0;
         ex_o_pc         <= '0;
         ex_o_change_pc  <= 1'b0;
         ex_o_next_pc    <= '0;
         ex_o_exception  <= 1'b0;
         squash_cnt      <= 2'd0;
      end else if (ex_i_flush) begin
         ex_o_ce        <= 1'b0;
         ex_o_rd_we     <= 1'b0;
         ex_o_change_pc <= 1'b0;
         ex_o_exception <= 1'b0;
         squash_cnt     <= 2'd0;
      end else if (ex_i_stall) begin
         // Everything freezes, but the redirect pulse must not be seen twice.
         ex_o_change_pc <= 1'b0;
      end else begin
         ex_o_ce        <= accept;
         ex_o_rd_we     <= accept & writes_rd;
         ex_o_change_pc <= accept & redirect;
         ex_o_exception <= accept & want_redirect & misaligned;
         if (accept) begin
            ex_o_result     <= result;
            ex_o_store_data <= ex_i_rs2;
            ex_o_addr_rd    <= ex_i_addr_rd;
            ex_o_opcode     <= ex_i_opcode;
            ex_o_funct3     <= ex_i_funct3;
            ex_o_pc         <= ex_i_pc;
            ex_o_next_pc    <= target;
         end
         if (accept & redirect)
            squash_cnt <= 2'(SQUASH_CYCLES);
         else if (squash_cnt != 2'd0)
            squash_cnt <= squash_cnt - 2'd1;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed scenarios plus random traffic
// checked against an instruction-level reference model.
module tb_execute_stage;

   localparam int SQUASH = 2;

   typedef enum int {RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE} op_e;
   typedef enum int {A_ADD, A_SUB, A_SLT, A_SLTU, A_XOR, A_OR, A_AND, A_SLL, A_SRL, A_SRA,
                     A_EQ, A_NEQ, A_GE, A_GEU} alu_e;

   typedef struct {
      op_e         op;
      alu_e        alu;
      logic [31:0] pc, rs1, rs2, imm;
      logic [4:0]  rd;
      logic [2:0]  funct3;
   } txn_t;

   typedef struct {
      logic [31:0] result, store_data, pc, next_pc;
      logic [4:0]  rd;
      logic        rd_we, change_pc, exception;
      logic [10:0] opcode;
      logic [2:0]  funct3;
   } exp_t;

   logic        ex_clk, ex_rst;
   logic        ex_i_ce, ex_i_stall, ex_i_flush;
   logic [31:0] ex_i_pc, ex_i_imm, ex_i_rs1, ex_i_rs2;
   logic [10:0] ex_i_opcode;
   logic [13:0] ex_i_alu;
   logic [2:0]  ex_i_funct3;
   logic [4:0]  ex_i_addr_rd;
   logic        ex_o_ce, ex_o_rd_we, ex_o_change_pc, ex_o_flush, ex_o_stall, ex_o_exception;
   logic [31:0] ex_o_result, ex_o_store_data, ex_o_pc, ex_o_next_pc;
   logic [4:0]  ex_o_addr_rd;
   logic [10:0] ex_o_opcode;
   logic [2:0]  ex_o_funct3;

   int   checks = 0;
   int   failures = 0;
   int   squash_left = 0;
   exp_t exp_q[$];

   execute_stage #(.SQUASH_CYCLES(SQUASH)) dut (
      .ex_clk(ex_clk), .ex_rst(ex_rst),
      .ex_i_ce(ex_i_ce), .ex_i_stall(ex_i_stall), .ex_i_flush(ex_i_flush),
      .ex_i_pc(ex_i_pc), .ex_i_opcode(ex_i_opcode), .ex_i_alu(ex_i_alu),
      .ex_i_funct3(ex_i_funct3), .ex_i_imm(ex_i_imm), .ex_i_rs1(ex_i_rs1),
      .ex_i_rs2(ex_i_rs2), .ex_i_addr_rd(ex_i_addr_rd),
      .ex_o_ce(ex_o_ce), .ex_o_result(ex_o_result), .ex_o_store_data(ex_o_store_data),
      .ex_o_addr_rd(ex_o_addr_rd), .ex_o_rd_we(ex_o_rd_we), .ex_o_opcode(ex_o_opcode),
      .ex_o_funct3(ex_o_funct3), .ex_o_pc(ex_o_pc), .ex_o_change_pc(ex_o_change_pc),
      .ex_o_next_pc(ex_o_next_pc), .ex_o_flush(ex_o_flush), .ex_o_stall(ex_o_stall),
      .ex_o_exception(ex_o_exception)
   );

   initial ex_clk = 1'b0;
   always #5 ex_clk = ~ex_clk;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference behaviour of one accepted instruction, straight from the ISA rules.
   function automatic exp_t model(input txn_t t);
      exp_t        e;
      logic [31:0] a, b, r, target;
      logic        taken;
      a = (t.op == JAL || t.op == AUIPC) ? t.pc : (t.op == LUI) ? 32'd0 : t.rs1;
      b = (t.op == RTYPE || t.op == BRANCH) ? t.rs2 : t.imm;
      case (t.alu)
         A_ADD:   r = a + b;
         A_SUB:   r = a - b;
         A_SLT:   r = ($signed(a) < $signed(b)) ? 1 : 0;
         A_SLTU:  r = (a < b) ? 1 : 0;
         A_XOR:   r = a ^ b;
         A_OR:    r = a | b;
         A_AND:   r = a & b;
         A_SLL:   r = a << b[4:0];
         A_SRL:   r = a >> b[4:0];
         A_SRA:   r = $unsigned($signed(a) >>> b[4:0]);
         A_EQ:    r = (a == b) ? 1 : 0;
         A_NEQ:   r = (a != b) ? 1 : 0;
         A_GE:    r = ($signed(a) >= $signed(b)) ? 1 : 0;
         A_GEU:   r = (a >= b) ? 1 : 0;
         default: r = 0;
      endcase
      taken  = (t.op == JAL) || (t.op == JALR) || (t.op == BRANCH && r == 1);
      target = (t.op == JALR) ? ((t.rs1 + t.imm) & 32'hFFFF_FFFE) : t.pc + t.imm;
      e.result     = (t.op == JAL || t.op == JALR) ? t.pc + 4 : r;
      e.store_data = t.rs2;
      e.rd         = t.rd;
      e.rd_we      = (t.op inside {RTYPE, ITYPE, LOAD, JAL, JALR, LUI, AUIPC}) && t.rd != 0;
      e.opcode     = 11'(1) << t.op;
      e.funct3     = t.funct3;
      e.pc         = t.pc;
      e.next_pc    = target;
      e.change_pc  = taken && target[1:0] == 2'b00;
      e.exception  = taken && target[1:0] != 2'b00;
      return e;
   endfunction

   function automatic txn_t mk(input op_e op, input alu_e alu, input logic [31:0] pc,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [4:0] rd);
      txn_t t;
      t.op = op; t.alu = alu; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2;
      t.imm = imm; t.rd = rd; t.funct3 = 3'd0;
      return t;
   endfunction

   function automatic txn_t rand_txn();
      txn_t       t;
      logic [11:0] i12;
      int         k;
      t.op     = op_e'($urandom_range(0, 10));
      t.pc     = $urandom & 32'h0000_FFFC;
      t.rs1    = $urandom;
      t.rs2    = ($urandom_range(0, 3) == 0) ? t.rs1 : $urandom;
      i12      = 12'($urandom);
      t.imm    = {{20{i12[11]}}, i12};
      t.rd     = 5'($urandom_range(0, 31));
      t.funct3 = 3'($urandom);
      t.alu    = A_ADD;
      case (t.op)
         RTYPE, ITYPE: t.alu = alu_e'($urandom_range(0, 9));
         BRANCH: begin
            k = $urandom_range(0, 5);
            t.alu = (k == 0) ? A_EQ : (k == 1) ? A_NEQ : (k == 2) ? A_SLT :
                    (k == 3) ? A_SLTU : (k == 4) ? A_GE : A_GEU;
            t.imm = ($urandom_range(0, 3) == 0) ? t.imm & 32'hFFFF_FFFE : t.imm & 32'hFFFF_FFFC;
         end
         JAL: t.imm = ($urandom_range(0, 3) == 0) ? t.imm & 32'hFFFF_FFFE : t.imm & 32'hFFFF_FFFC;
         JALR: begin
            t.rs1 = (t.rs1 & 32'h0000_FFFC) | 32'($urandom_range(0, 1));
            t.imm = ($urandom_range(0, 3) == 0) ? t.imm : t.imm & 32'hFFFF_FFFC;
         end
         default: ;
      endcase
      return t;
   endfunction

   // Drive one cycle of inputs, advance the model, then wait past the edge.
   task automatic step(input txn_t t, input bit ce, input bit stall, input bit flush);
      ex_i_ce      = ce;
      ex_i_stall   = stall;
      ex_i_flush   = flush;
      ex_i_pc      = t.pc;
      ex_i_opcode  = 11'(1) << t.op;
      ex_i_alu     = 14'(1) << t.alu;
      ex_i_funct3  = t.funct3;
      ex_i_imm     = t.imm;
      ex_i_rs1     = t.rs1;
      ex_i_rs2     = t.rs2;
      ex_i_addr_rd = t.rd;
      if (flush)
         squash_left = 0;
      else if (!stall) begin
         if (ce && squash_left == 0) begin
            exp_q.push_back(model(t));
            if (model(t).change_pc) squash_left = SQUASH;
         end else if (squash_left > 0)
            squash_left--;
      end
      @(posedge ex_clk);
      #1;
   endtask

   task automatic assert_reset();
      ex_rst = 1'b1;
      squash_left = 0;
      exp_q.delete();
   endtask

   initial begin : monitor
      logic        rst_e, st_e, fl_e, exp_ce, exp_chg;
      logic [31:0] held;
      exp_t        e;
      exp_ce = 1'b0;
      held   = '0;
      forever begin
         @(posedge ex_clk);
         rst_e = ex_rst;
         st_e  = ex_i_stall;
         fl_e  = ex_i_flush;
         @(negedge ex_clk);
         exp_chg = 1'b0;
         if (rst_e || ex_rst) begin
            exp_ce = 1'b0;
            continue;
         end
         if (fl_e) begin
            check("flush_ce", ex_o_ce, 0);
            check("flush_rd_we", ex_o_rd_we, 0);
            check("flush_exc", ex_o_exception, 0);
            exp_ce = 1'b0;
         end else if (st_e) begin
            check("stall_ce_hold", ex_o_ce, exp_ce);
            if (exp_ce) check("stall_result_hold", ex_o_result, held);
         end else if (ex_o_ce) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ce", ex_o_ce, 0);
               exp_ce = 1'b0;
            end else begin
               e = exp_q.pop_front();
               check("result", ex_o_result, e.result);
               check("store_data", ex_o_store_data, e.store_data);
               check("addr_rd", ex_o_addr_rd, e.rd);
               check("rd_we", ex_o_rd_we, e.rd_we);
               check("opcode", ex_o_opcode, e.opcode);
               check("funct3", ex_o_funct3, e.funct3);
               check("pc", ex_o_pc, e.pc);
               check("exception", ex_o_exception, e.exception);
               if (e.change_pc) check("next_pc", ex_o_next_pc, e.next_pc);
               exp_chg = e.change_pc;
               exp_ce  = 1'b1;
               held    = e.result;
            end
         end else begin
            check("idle_exc", ex_o_exception, 0);
            exp_ce = 1'b0;
         end
         check("change_pc", ex_o_change_pc, exp_chg);
         check("flush_out", ex_o_flush, exp_chg | ex_i_flush);
         check("stall_out", ex_o_stall, ex_i_stall);
      end
   end

   initial begin : stimulus
      txn_t nop;
      nop = mk(ITYPE, A_ADD, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
      ex_rst = 1'b1;
      ex_i_ce = 0; ex_i_stall = 0; ex_i_flush = 0; ex_i_pc = 0; ex_i_opcode = 0;
      ex_i_alu = 0; ex_i_funct3 = 0; ex_i_imm = 0; ex_i_rs1 = 0; ex_i_rs2 = 0; ex_i_addr_rd = 0;
      repeat (2) @(posedge ex_clk);
      #1;
      check("rst_regs", {ex_o_ce, ex_o_result, ex_o_store_data, ex_o_addr_rd, ex_o_rd_we,
                         ex_o_opcode, ex_o_funct3, ex_o_pc, ex_o_change_pc, ex_o_next_pc,
                         ex_o_exception}, 0);
      check("rst_flush", ex_o_flush, 0);
      ex_rst = 1'b0;

      // ADDI 7 + (-3) into x5
      step(mk(ITYPE, A_ADD, 32'h10, 32'd7, 32'd0, 32'hFFFF_FFFD, 5'd5), 1, 0, 0);
      check("addi_ce", ex_o_ce, 1);
      check("addi_result", ex_o_result, 4);
      check("addi_rd_we", ex_o_rd_we, 1);
      check("addi_rd", ex_o_addr_rd, 5);

      // Taken BEQ, then two squashed inputs and one accepted
      step(mk(BRANCH, A_EQ, 32'h100, 32'd9, 32'd9, 32'h20, 5'd0), 1, 0, 0);
      check("beq_change", ex_o_change_pc, 1);
      check("beq_next_pc", ex_o_next_pc, 32'h120);
      check("beq_flush", ex_o_flush, 1);
      step(mk(ITYPE, A_ADD, 32'h104, 32'd1, 32'd0, 32'd1, 5'd2), 1, 0, 0);
      check("squash1_ce", ex_o_ce, 0);
      check("squash1_change", ex_o_change_pc, 0);
      step(mk(ITYPE, A_ADD, 32'h108, 32'd2, 32'd0, 32'd1, 5'd2), 1, 0, 0);
      check("squash2_ce", ex_o_ce, 0);
      step(mk(ITYPE, A_ADD, 32'h120, 32'd3, 32'd0, 32'd1, 5'd2), 1, 0, 0);
      check("post_squash_ce", ex_o_ce, 1);

      // Aligned JALR redirects; 0x203 and 0x206 clear only bit 0 and stay misaligned
      step(mk(JALR, A_ADD, 32'h40, 32'h201, 32'd0, 32'd0, 5'd1), 1, 0, 0);
      check("jalr_change", ex_o_change_pc, 1);
      check("jalr_next_pc", ex_o_next_pc, 32'h200);
      check("jalr_link", ex_o_result, 32'h44);
      step(nop, 0, 0, 0);
      step(nop, 0, 0, 0);
      step(mk(JALR, A_ADD, 32'h40, 32'h203, 32'd0, 32'd0, 5'd1), 1, 0, 0);
      check("jalr203_exc", ex_o_exception, 1);
      check("jalr203_change", ex_o_change_pc, 0);
      check("jalr203_ce", ex_o_ce, 1);
      step(mk(JALR, A_ADD, 32'h40, 32'h206, 32'd0, 32'd0, 5'd1), 1, 0, 0);
      check("jalr206_exc", ex_o_exception, 1);
      check("jalr206_change", ex_o_change_pc, 0);

      // Shift and compare corners
      step(mk(RTYPE, A_SRA, 32'h50, 32'h8000_0000, 32'd4, 32'd0, 5'd3), 1, 0, 0);
      check("sra", ex_o_result, 32'hF800_0000);
      step(mk(RTYPE, A_SLTU, 32'h54, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd3), 1, 0, 0);
      check("sltu", ex_o_result, 1);
      step(mk(RTYPE, A_SLT, 32'h58, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd3), 1, 0, 0);
      check("slt", ex_o_result, 0);

      // Stall three cycles behind a taken branch; the squash count must freeze
      step(mk(BRANCH, A_EQ, 32'h200, 32'd3, 32'd3, 32'h40, 5'd0), 1, 0, 0);
      check("stall_br_change", ex_o_change_pc, 1);
      for (int i = 0; i < 3; i++) begin
         step(mk(ITYPE, A_ADD, 32'h204, 32'd1, 32'd0, 32'd1, 5'd4), 1, 1, 0);
         check("stalled_change", ex_o_change_pc, 0);
         check("stalled_ce", ex_o_ce, 1);
         check("stalled_result", ex_o_result, 1);
      end
      step(mk(ITYPE, A_ADD, 32'h204, 32'd1, 32'd0, 32'd1, 5'd4), 1, 0, 0);
      check("frozen_sq1", ex_o_ce, 0);
      step(mk(ITYPE, A_ADD, 32'h208, 32'd1, 32'd0, 32'd1, 5'd4), 1, 0, 0);
      check("frozen_sq2", ex_o_ce, 0);
      step(mk(ITYPE, A_ADD, 32'h240, 32'd1, 32'd0, 32'd1, 5'd4), 1, 0, 0);
      check("frozen_accept", ex_o_ce, 1);
      step(mk(ITYPE, A_ADD, 32'h244, 32'd1, 32'd0, 32'd1, 5'd4), 1, 1, 1);
      check("flush_stall_ce", ex_o_ce, 0);

      // Async reset in the middle of a squash window
      step(mk(BRANCH, A_NEQ, 32'h300, 32'd1, 32'd2, 32'h80, 5'd0), 1, 0, 0);
      check("rst_br_change", ex_o_change_pc, 1);
      #2;
      assert_reset();
      #1;
      check("midrst_regs", {ex_o_ce, ex_o_result, ex_o_store_data, ex_o_addr_rd, ex_o_rd_we,
                            ex_o_opcode, ex_o_funct3, ex_o_pc, ex_o_change_pc, ex_o_next_pc,
                            ex_o_exception}, 0);
      check("midrst_flush", ex_o_flush, 0);
      @(posedge ex_clk);
      #1;
      ex_rst = 1'b0;
      step(mk(ITYPE, A_ADD, 32'h304, 32'd10, 32'd0, 32'd5, 5'd6), 1, 0, 0);
      check("after_rst_ce", ex_o_ce, 1);
      check("after_rst_result", ex_o_result, 15);

      for (int i = 0; i < 600; i++)
         step(rand_txn(), $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
              $urandom_range(0, 19) == 0);

      repeat (4) step(nop, 0, 0, 0);
      check("drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
